// File: rtl/operand_forward_scoreboard_pkg.sv
// operand_forward_scoreboard_pkg: shared tag struct, bypass constants and select-width helper
// for the operand forwarding scoreboard.
package operand_forward_scoreboard_pkg;
    localparam int BYPASS_RF = 0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } tag_t;

    function automatic int sel_w(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction
endpackage

// File: rtl/operand_forward_scoreboard_if.sv
// operand_forward_scoreboard_if: issue, operand-read and bypass signals of the decode operand network.
interface operand_forward_scoreboard_if
    import operand_forward_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_STAGES     = 4,
    parameter int NUM_READ_PORTS = 2
);
    localparam int SEL_W = sel_w(NUM_STAGES);

    logic                                 issue_valid;
    logic [4:0]                           issue_rd;
    logic                                 issue_writes;
    logic                                 issue_is_load;
    logic                                 stall_in;
    logic [NUM_STAGES:0]                  flush_mask;
    logic [NUM_READ_PORTS*5-1:0]          rs_addr;
    logic [NUM_READ_PORTS-1:0]            rs_used;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rf_data;
    logic [NUM_STAGES*DATA_WIDTH-1:0]     stage_result;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rs_data;
    logic [NUM_READ_PORTS*SEL_W-1:0]      bypass_sel;
    logic                                 hazard_stall;
    logic                                 scan;

    modport master (
        output issue_valid, issue_rd, issue_writes, issue_is_load, stall_in, flush_mask,
               rs_addr, rs_used, rf_data, stage_result, scan,
        input  rs_data, bypass_sel, hazard_stall
    );

    modport slave (
        input  issue_valid, issue_rd, issue_writes, issue_is_load, stall_in, flush_mask,
               rs_addr, rs_used, rf_data, stage_result, scan,
        output rs_data, bypass_sel, hazard_stall
    );
endinterface

// File: rtl/operand_forward_scoreboard_port_sel.sv
// operand_forward_scoreboard_port_sel: per read port youngest-producer match, select encoding,
// operand mux and load not-ready flag.
module operand_forward_scoreboard_port_sel
    import operand_forward_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_STAGES       = 4,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 3
) (
    input  tag_t [NUM_STAGES-1:0]          i_tags,
    input  logic [4:0]                     i_rs_addr,
    input  logic [DATA_WIDTH-1:0]          i_rf_data,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] i_stage_result,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [SEL_W-1:0]               o_sel,
    output logic                           o_not_ready
);
    // Oldest stage first so the youngest matching producer overrides last.
    always_comb begin
        o_sel       = SEL_W'(BYPASS_RF);
        o_data      = i_rf_data;
        o_not_ready = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (i_tags[k].valid && i_tags[k].rd == i_rs_addr && i_rs_addr != 5'd0) begin
                o_sel       = SEL_W'(k + 1);
                o_data      = i_stage_result[k*DATA_WIDTH +: DATA_WIDTH];
                o_not_ready = i_tags[k].is_load && (k < LOAD_READY_STAGE);
            end
        end
    end
endmodule

// File: rtl/operand_forward_scoreboard.sv
// operand_forward_scoreboard: in-flight destination tag pipeline generating bypass selects and
// load-use stall. Optional hazard/bypass counters enabled by OPERAND_FORWARD_STATS_EN.
module operand_forward_scoreboard
    import operand_forward_scoreboard_pkg::*;
#(
    parameter int CORE             = 0,
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_STAGES       = 4,
    parameter int NUM_READ_PORTS   = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SCAN_CYCLES_MIN  = 0,
    parameter int SCAN_CYCLES_MAX  = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    operand_forward_scoreboard_if.slave  bus
`ifdef OPERAND_FORWARD_STATS_EN
    ,
    output logic [31:0]                  hazard_cycles,
    output logic [31:0]                  bypass_hits
`endif
);
    localparam int SEL_W = sel_w(NUM_STAGES);

    tag_t [NUM_STAGES-1:0]                r_tags;
    tag_t [NUM_STAGES-1:0]                w_kept;
    tag_t [NUM_STAGES-1:0]                w_next;
    tag_t                                 w_ins;
    logic [31:0]                          r_cycle;
    logic [NUM_READ_PORTS-1:0]            w_not_ready;
    logic [NUM_READ_PORTS*SEL_W-1:0]      w_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] w_data;
    logic                                 w_hazard;

    genvar g;
    generate
        for (g = 0; g < NUM_READ_PORTS; g++) begin : g_port
            operand_forward_scoreboard_port_sel #(
                .DATA_WIDTH      (DATA_WIDTH),
                .NUM_STAGES      (NUM_STAGES),
                .LOAD_READY_STAGE(LOAD_READY_STAGE),
                .SEL_W           (SEL_W)
            ) u_sel (
                .i_tags        (r_tags),
                .i_rs_addr     (bus.rs_addr[g*5 +: 5]),
                .i_rf_data     (bus.rf_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_stage_result(bus.stage_result),
                .o_data        (w_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_sel         (w_sel[g*SEL_W +: SEL_W]),
                .o_not_ready   (w_not_ready[g])
            );
        end
    endgenerate

    assign w_hazard         = |(w_not_ready & bus.rs_used);
    assign bus.hazard_stall = w_hazard;
    assign bus.bypass_sel   = w_sel;
    assign bus.rs_data      = w_data;

    assign w_ins = '{
        valid:   bus.issue_valid & bus.issue_writes & (bus.issue_rd != 5'd0) & ~w_hazard & ~bus.flush_mask[0],
        rd:      bus.issue_rd,
        is_load: bus.issue_is_load
    };

    // Flush bits name the current occupant, so kill before shifting or holding.
    always_comb begin
        w_kept = r_tags;
        for (int k = 0; k < NUM_STAGES; k++) w_kept[k].valid = r_tags[k].valid & ~bus.flush_mask[k+1];
        w_next = bus.stall_in ? w_kept : {w_kept[NUM_STAGES-2:0], w_ins};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tags  <= '0;
            r_cycle <= '0;
        end else begin
            r_tags  <= w_next;
            r_cycle <= r_cycle + 32'd1;
        end
    end

`ifdef OPERAND_FORWARD_STATS_EN
    logic [31:0] r_hazard_cycles;
    logic [31:0] r_bypass_hits;
    logic        w_hit;

    always_comb begin
        w_hit = 1'b0;
        for (int p = 0; p < NUM_READ_PORTS; p++) w_hit = w_hit | (bus.rs_used[p] & (|w_sel[p*SEL_W +: SEL_W]));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hazard_cycles <= '0;
            r_bypass_hits   <= '0;
        end else begin
            if (w_hazard && !(&r_hazard_cycles)) r_hazard_cycles <= r_hazard_cycles + 32'd1;
            if (w_hit && !(&r_bypass_hits)) r_bypass_hits <= r_bypass_hits + 32'd1;
        end
    end

    assign hazard_cycles = r_hazard_cycles;
    assign bypass_hits   = r_bypass_hits;
`endif

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && bus.scan && longint'(r_cycle) >= longint'(SCAN_CYCLES_MIN) &&
            longint'(r_cycle) <= longint'(SCAN_CYCLES_MAX)) begin
            for (int p = 0; p < NUM_READ_PORTS; p++)
                $display("core%0d cycle %0d port %0d sel %0d data %h hazard %0b", CORE, r_cycle, p,
                         w_sel[p*SEL_W +: SEL_W], w_data[p*DATA_WIDTH +: DATA_WIDTH], w_hazard);
        end
    end
`endif
endmodule
